// File: rtl/pipe_buff_pkg.sv
// Shared types and helpers for the two-entry skid pipeline stage.
package pipe_buff_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buff_state_e;

    function automatic int payload_width(input int wb_size, input int mem_size,
                                         input int flag_size, input int data_w,
                                         input int pc_w, input int rdst_w);
        return wb_size + mem_size + flag_size + (2 * data_w) + pc_w + rdst_w;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with asynchronous active-low clear.
module pipe_payload_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_r;

    // Capture the payload only when a transfer targets this entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
        end else if (load) begin
            data_r <= d;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/pipe_stage_buff.sv
// Two-entry skid pipeline register: main entry drives the outputs, skid entry
// catches the word accepted while downstream stalls.
module pipe_stage_buff
    import pipe_buff_pkg::*;
#(
    parameter int WB_SIZE   = 4,
    parameter int MEM_SIZE  = 6,
    parameter int FLAG_SIZE = 4,
    parameter int DATA_W    = 16,
    parameter int PC_W      = 32,
    parameter int RDST_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_ready,
    output logic                 o_valid,
    input  logic [WB_SIZE-1:0]   i_WB,
    input  logic [MEM_SIZE-1:0]  i_Mem,
    input  logic [PC_W-1:0]      i_pc,
    input  logic [RDST_W-1:0]    i_Rdst,
    input  logic [DATA_W-1:0]    i_alu,
    input  logic [DATA_W-1:0]    i_read_data1,
    input  logic [FLAG_SIZE-1:0] i_flag,
    output logic [WB_SIZE-1:0]   o_WB,
    output logic [MEM_SIZE-1:0]  o_Mem,
    output logic [PC_W-1:0]      o_pc,
    output logic [RDST_W-1:0]    o_Rdst,
    output logic [DATA_W-1:0]    o_alu,
    output logic [DATA_W-1:0]    o_read_data1,
    output logic [FLAG_SIZE-1:0] o_flag,
    output logic [1:0]           o_count
);

    localparam int PW = payload_width(WB_SIZE, MEM_SIZE, FLAG_SIZE, DATA_W, PC_W, RDST_W);

    buff_state_e state_r;
    logic        ready_r;
    logic        valid_r;
    logic [1:0]  count_r;

    logic          up_xfer_s;
    logic          dn_xfer_s;
    logic          main_load_s;
    logic          skid_load_s;
    logic          main_from_skid_s;
    logic [PW-1:0] in_pay_s;
    logic [PW-1:0] main_d_s;
    logic [PW-1:0] main_pay_s;
    logic [PW-1:0] skid_pay_s;

    logic [WB_SIZE-1:0]  main_wb_s;
    logic [MEM_SIZE-1:0] main_mem_s;

    assign in_pay_s  = {i_WB, i_Mem, i_pc, i_Rdst, i_alu, i_read_data1, i_flag};
    assign up_xfer_s = i_valid & ready_r;
    assign dn_xfer_s = valid_r & i_ready;

    // Steer the incoming word to main or skid; a flush suppresses every load.
    always_comb begin
        main_load_s      = 1'b0;
        skid_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (i_flush) begin
            main_load_s = 1'b0;
        end else begin
            case (state_r)
                EMPTY: main_load_s = up_xfer_s;
                ONE: begin
                    main_load_s = up_xfer_s & dn_xfer_s;
                    skid_load_s = up_xfer_s & ~dn_xfer_s;
                end
                FULL: begin
                    main_load_s      = dn_xfer_s;
                    main_from_skid_s = 1'b1;
                end
                default: main_load_s = 1'b0;
            endcase
        end
    end

    assign main_d_s = main_from_skid_s ? skid_pay_s : in_pay_s;

    pipe_payload_reg #(.WIDTH(PW)) u_main (
        .clk   (clk),
        .rst_n (rst),
        .load  (main_load_s),
        .d     (main_d_s),
        .q     (main_pay_s)
    );

    pipe_payload_reg #(.WIDTH(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst),
        .load  (skid_load_s),
        .d     (in_pay_s),
        .q     (skid_pay_s)
    );

    // Occupancy FSM; ready/valid/count are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= EMPTY;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            count_r <= 2'd0;
        end else if (i_flush) begin
            state_r <= EMPTY;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            count_r <= 2'd0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (up_xfer_s) begin
                        state_r <= ONE;
                        ready_r <= 1'b1;
                        valid_r <= 1'b1;
                        count_r <= 2'd1;
                    end
                end
                ONE: begin
                    if (up_xfer_s && !dn_xfer_s) begin
                        state_r <= FULL;
                        ready_r <= 1'b0;
                        valid_r <= 1'b1;
                        count_r <= 2'd2;
                    end else if (!up_xfer_s && dn_xfer_s) begin
                        state_r <= EMPTY;
                        ready_r <= 1'b1;
                        valid_r <= 1'b0;
                        count_r <= 2'd0;
                    end
                end
                FULL: begin
                    if (dn_xfer_s) begin
                        state_r <= ONE;
                        ready_r <= 1'b1;
                        valid_r <= 1'b1;
                        count_r <= 2'd1;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                    count_r <= 2'd0;
                end
            endcase
        end
    end

    assign {main_wb_s, main_mem_s, o_pc, o_Rdst, o_alu, o_read_data1, o_flag} = main_pay_s;

    // Control fields become a bubble whenever no entry is presented.
    assign o_WB    = valid_r ? main_wb_s  : {WB_SIZE{1'b0}};
    assign o_Mem   = valid_r ? main_mem_s : {MEM_SIZE{1'b0}};
    assign o_valid = valid_r;
    assign o_ready = ready_r;
    assign o_count = count_r;

endmodule

// File: tb/tb_pipe_stage_buff.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed streaming, stall, flush and reset scenarios with literal expectations.
module tb_pipe_stage_buff;

    localparam int PW = 4 + 6 + 32 + 3 + 16 + 16 + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic [3:0]  i_WB = 4'd0;
    logic [5:0]  i_Mem = 6'd0;
    logic [31:0] i_pc = 32'd0;
    logic [2:0]  i_Rdst = 3'd0;
    logic [15:0] i_alu = 16'd0;
    logic [15:0] i_read_data1 = 16'd0;
    logic [3:0]  i_flag = 4'd0;
    logic [3:0]  o_WB;
    logic [5:0]  o_Mem;
    logic [31:0] o_pc;
    logic [2:0]  o_Rdst;
    logic [15:0] o_alu;
    logic [15:0] o_read_data1;
    logic [3:0]  o_flag;
    logic [1:0]  o_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [PW-1:0] q[$];
    logic [PW-1:0] last_head = '0;

    pipe_stage_buff dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_ready(i_ready), .o_valid(o_valid),
        .i_WB(i_WB), .i_Mem(i_Mem), .i_pc(i_pc), .i_Rdst(i_Rdst), .i_alu(i_alu),
        .i_read_data1(i_read_data1), .i_flag(i_flag),
        .o_WB(o_WB), .o_Mem(o_Mem), .o_pc(o_pc), .o_Rdst(o_Rdst), .o_alu(o_alu),
        .o_read_data1(o_read_data1), .o_flag(o_flag), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_word(input logic [3:0] wb, input logic [5:0] mem, input logic [31:0] pc,
                            input logic [15:0] alu);
        i_WB = wb; i_Mem = mem; i_pc = pc; i_Rdst = pc[2:0];
        i_alu = alu; i_read_data1 = ~alu; i_flag = alu[3:0];
    endtask

    // Reference model: FIFO of at most two words, flush empties it, reset clears all.
    initial begin
        logic in_x, out_x;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                last_head = '0;
            end else begin
                in_x  = i_valid && (q.size() < 2);
                out_x = (q.size() > 0) && i_ready;
                if (i_flush) begin
                    q.delete();
                end else begin
                    if (out_x) void'(q.pop_front());
                    if (in_x) q.push_back({i_WB, i_Mem, i_pc, i_Rdst, i_alu, i_read_data1, i_flag});
                end
                if (q.size() > 0) last_head = q[0];
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [PW-1:0] exp_pay;
        logic [PW+3:0] exp_all;
        logic [PW+3:0] act_all;
        exp_pay = (q.size() > 0) ? q[0] : last_head;
        if (q.size() == 0) exp_pay[PW-1:PW-10] = 10'd0;
        exp_all = {(q.size() > 0), (q.size() < 2), 2'(q.size()), exp_pay};
        act_all = {o_valid, o_ready, o_count,
                   o_WB, o_Mem, o_pc, o_Rdst, o_alu, o_read_data1, o_flag};
        chk("model", 128'(act_all), 128'(exp_all));
        if (o_count > 2'd2) chk("count_range", 128'(o_count), 128'd2);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_ready", 128'(o_ready), 128'd1);
        chk("rst_count", 128'(o_count), 128'd0);
        chk("rst_pc", 128'(o_pc), 128'd0);
        rst = 1'b1;

        // Streaming with one-cycle lag.
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            set_word(4'h1, 6'h01, 32'(k), 16'(k));
            @(negedge clk);
            chk("stream_alu", 128'(o_alu), 128'(k));
            chk("stream_count", 128'(o_count), 128'd1);
        end
        i_valid = 1'b0;
        @(negedge clk);

        // Stall: two words fill main and skid.
        i_ready = 1'b0;
        i_valid = 1'b1;
        set_word(4'h3, 6'h0A, 32'hA, 16'h00AA);
        @(negedge clk);
        set_word(4'h5, 6'h0B, 32'hB, 16'h00BB);
        @(negedge clk);
        i_valid = 1'b0;
        chk("stall_count", 128'(o_count), 128'd2);
        chk("stall_ready", 128'(o_ready), 128'd0);
        chk("stall_alu", 128'(o_alu), 128'h00AA);
        @(negedge clk);
        chk("stall_hold", 128'(o_alu), 128'h00AA);
        i_ready = 1'b1;
        @(negedge clk);
        chk("drain_b", 128'(o_alu), 128'h00BB);
        chk("drain_ready", 128'(o_ready), 128'd1);
        @(negedge clk);
        chk("drain_empty", 128'(o_valid), 128'd0);
        chk("bubble_wb", 128'(o_WB), 128'd0);
        chk("hold_alu", 128'(o_alu), 128'h00BB);

        // Flush while full with a word on offer.
        i_ready = 1'b0;
        i_valid = 1'b1;
        set_word(4'h7, 6'h11, 32'h11, 16'h0011);
        @(negedge clk);
        set_word(4'h9, 6'h22, 32'h22, 16'h0022);
        @(negedge clk);
        i_flush = 1'b1;
        i_ready = 1'b1;
        set_word(4'hC, 6'h33, 32'h33, 16'h0033);
        @(negedge clk);
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_valid", 128'(o_valid), 128'd0);
        chk("flush_mem", 128'(o_Mem), 128'd0);
        chk("flush_count", 128'(o_count), 128'd0);
        chk("flush_ready", 128'(o_ready), 128'd1);
        @(negedge clk);
        chk("flush_discard", 128'(o_valid), 128'd0);

        // Asynchronous reset while one word is held.
        i_ready = 1'b0;
        i_valid = 1'b1;
        set_word(4'hF, 6'h3F, 32'h5555, 16'h5555);
        @(negedge clk);
        i_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 128'(o_valid), 128'd0);
        chk("async_alu", 128'(o_alu), 128'd0);
        chk("async_pc", 128'(o_pc), 128'd0);
        chk("async_count", 128'(o_count), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        set_word(4'h2, 6'h02, 32'h00001234, 16'h1234);
        @(negedge clk);
        i_valid = 1'b0;
        chk("post_rst_pc", 128'(o_pc), 128'h00001234);
        chk("post_rst_valid", 128'(o_valid), 128'd1);

        // Random handshake toggling; the model checks order and loss every cycle.
        for (int c = 0; c < 10000; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = 1'($urandom_range(0, 1));
            set_word(4'($urandom), 6'($urandom), $urandom, 16'($urandom));
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_empty", 128'(o_count), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buff.md
PIPE_STAGE_BUFF -- requirements
Module: pipe_stage_buff

Interface
REQ-001 Parameters SHALL be: WB_SIZE, default 4, write-back control width; MEM_SIZE, default 6, memory control width; FLAG_SIZE, default 4, flag width; DATA_W, default 16, ALU/operand width; PC_W, default 32, PC width; RDST_W, default 3, destination register index width.
REQ-002 The block SHALL use one clock, clk; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, in order: clk in 1 clock; rst in 1 async active-low reset; i_flush in 1 synchronous squash; i_valid in 1 upstream data valid; o_ready out 1 upstream may send; i_ready in 1 downstream accepts; o_valid out 1 output entry valid.
REQ-004 Payload inputs SHALL be: i_WB in WB_SIZE; i_Mem in MEM_SIZE; i_pc in PC_W; i_Rdst in RDST_W; i_alu in DATA_W; i_read_data1 in DATA_W; i_flag in FLAG_SIZE.
REQ-005 Payload outputs SHALL be o_WB, o_Mem, o_pc, o_Rdst, o_alu, o_read_data1 and o_flag, each the same width as its input.
REQ-006 Port o_count out 2 SHALL report the number of entries held (0..2).

Function
REQ-007 The block SHALL be a 2-entry skid pipeline register: a main entry drives the outputs, and a skid entry absorbs one word when downstream stalls.
REQ-008 An upstream transfer SHALL occur when i_valid and o_ready are both high at a rising clk edge; a downstream transfer SHALL occur when o_valid and i_ready are both high.
REQ-009 o_ready SHALL be registered and equal to (state != FULL), with no combinational path from i_ready.
REQ-010 The state machine SHALL have three states: EMPTY, ONE and FULL.
REQ-011 In EMPTY, an upstream transfer SHALL load the main entry and go to ONE.
REQ-012 In ONE: in-only SHALL go to FULL with the word in skid; out-only SHALL go to EMPTY; in and out together SHALL reload main and stay in ONE; neither SHALL hold.
REQ-013 In FULL, no upstream transfer is possible; on a downstream transfer, skid SHALL move to main and the state SHALL go to ONE.
REQ-014 Latency SHALL be 1 cycle: a word accepted at edge N appears on the outputs with o_valid=1 after edge N when the block is EMPTY, or when it is ONE with a simultaneous out.
REQ-015 Ordering SHALL be strict FIFO; no word is dropped or duplicated.
REQ-016 While o_valid=0, o_WB and o_Mem SHALL be forced to 0 (bubble); the other outputs are don't-care but SHALL hold their last value.
REQ-017 i_flush at an edge SHALL empty both entries and go to EMPTY, ignoring any simultaneous upstream or downstream transfer; o_ready SHALL be 1 in the following cycle.
REQ-018 o_count SHALL be 0, 1 or 2 for EMPTY, ONE or FULL respectively.
REQ-019 Payload registers SHALL load only on a transfer, so that stall holds all fields stable.

Reset
REQ-020 While rst=0, the state SHALL be EMPTY, o_valid=0, o_ready=1, o_count=0, and all payload registers SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-transfer SHALL discard all held words; the first transfer after deassertion SHALL be accepted at the first edge with rst=1.

Structure
REQ-022 Package pipe_buff_pkg SHALL hold the state enum (EMPTY, ONE, FULL) and a function computing the payload width from the parameters.
REQ-023 The payload SHALL be handled internally as one concatenated vector.
REQ-024 One sub-module, pipe_payload_reg (parametrised width, load enable, async active-low clear), SHALL be instantiated twice, once for main and once for skid.

Verification
REQ-025 Streaming: i_valid=1 and i_ready=1 with i_alu=1,2,3,... -> o_alu=1,2,3 on consecutive cycles, 1-cycle lag, o_count=1 throughout.
REQ-026 Stall: send A=0x00AA and B=0x00BB with i_ready=0 -> o_count=2, o_ready=0, o_alu=0x00AA held; then i_ready=1 -> 0x00AA, then 0x00BB, and o_ready=1 one cycle after the first out.
REQ-027 Flush in FULL with i_valid=1 -> next cycle o_valid=0, o_WB=0, o_Mem=0, o_count=0, and the offered word is discarded.
REQ-028 Reset: assert rst=0 asynchronously between edges while in ONE -> o_valid drops immediately and all outputs read 0; after release, a word i_pc=0x00001234 appears 1 cycle later.
REQ-029 Random i_valid/i_ready toggling over 10000 cycles -> scoreboard shows in-order, lossless delivery and o_count always within 0..2.
